reg_dump_seq: RTL and testbench
===============================

# reg_dump_seq

Debug dump sequencer at the far end of the register file's debug port. On request it drives the 4-bit debug select (`m_state`) through 0..15, samples the 32-bit debug word (`m_data`) after a settle delay, and streams the selected register (`m_data[31:16]`) out over a valid/ready interface with its index. It sits between the register file and whatever debug sink (UART framer, display driver, logic-analyser port) consumes register snapshots.

## Interface
Parameters:
- `SETTLE_CYCLES`, 1: cycles `m_state` is held before `m_data` is sampled; legal range 1..15; 0 is illegal.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `nClear`  in  1  asynchronous active-low reset.
- `start`  in  1  level; sampled only in IDLE; begins a dump.
- `cont`  in  1  continuous mode; sampled at the last handshake.
- `m_state`  out  4  debug select to the register file.
- `m_data`  in  32  debug word from the register file; `{r[m_state], r[m_state+1]}`.
- `out_data`  out  16  register value.
- `out_idx`  out  5  register index 0..15; 16 = checksum word.
- `out_valid`  out  1  `out_data`/`out_idx`/`out_last` valid.
- `out_ready`  in  1  sink accepts the word.
- `out_last`  out  1  final word of the dump.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- FSM states: IDLE, SELECT, SEND, CSUM (CSUM only with the macro).
- IDLE: `busy`=0. `start`=1 at an edge → SELECT, idx=0, checksum accumulator cleared.
- SELECT: `m_state`=idx. Held SETTLE_CYCLES cycles. On the edge ending the last SELECT cycle: `out_data`<=`m_data[31:16]`, `out_idx`<=idx, accumulator ^= `m_data[31:16]`, `out_valid`<=1, → SEND.
- SEND: outputs and `m_state` held stable while `out_valid`=1 and `out_ready`=0. A handshake is `out_valid`&`out_ready` at an edge.
  - On handshake with idx<15: idx+1, → SELECT.
  - On handshake with idx=15: → CSUM with the macro. Without it, this is the last word.
- Final handshake: `done` pulses 1 cycle. If `cont`=1 → SELECT idx 0 with the accumulator cleared. Otherwise → IDLE.
- `busy`=1 in every state except IDLE.
- `start` while `busy` is ignored. `out_ready` without `out_valid` is ignored.
- `m_data[15:0]` is unused.

## Timing
- Reset values: `m_state`=0, `out_data`=0, `out_idx`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, accumulator=0, state=IDLE.
- `start` seen at edge of cycle 0 → SELECT in cycles 1..SETTLE_CYCLES → `out_valid` high in cycle 1+SETTLE_CYCLES.
- With `out_ready` tied to 1: one word every SETTLE_CYCLES+1 cycles.
- `out_valid` deasserts the cycle after a handshake and reasserts after the next SELECT.
- `done` is high in the cycle after the final handshake.
- `nClear` low at any point, including mid-SEND: all registers return to reset values immediately (asynchronously). A dump is never resumed. The next `start` begins at idx 0.

## Configuration
- `REG_DUMP_CSUM_EN` defined:
  - After idx 15 is accepted, CSUM presents `out_data` = XOR of the 16 captured words, `out_idx`=16, `out_last`=1.
  - `out_valid` rises the cycle after the idx-15 handshake.
  - The CSUM handshake is the final handshake.
- Undefined: no CSUM state and no accumulator. `out_last`=1 on idx 15, which is the final word.

## Structure
- Shared package `reg_dump_pkg`: FSM state enum, `NUM_REGS`=16, `CSUM_IDX`=5'd16, `REG_W`=16.
- Single module. No sub-module is warranted; the accumulator is a 16-bit XOR register inside the `ifdef`.

## Test plan
- Reset: assert `nClear`=0 with `start`=1 → every output 0, state IDLE. Release → still IDLE until `start`.
- Basic dump, SETTLE_CYCLES=1, `out_ready`=1, r_n=16'h1000+n, start at cycle 0:
  - `out_valid` first high at cycle 2 with 0x1000/idx 0.
  - 16 words 0x1000..0x100F, one every 2 cycles.
  - `out_last` on idx 15 (macro off), `done` one cycle after that handshake.
- Backpressure: `out_ready`=0 for 5 cycles while idx 3 is presented → `out_data`=0x1003, `m_state`=3, `out_valid`=1 held. Release → idx 4 follows after SETTLE_CYCLES+1 cycles.
- Checksum (macro on): r5=16'hBEEF, all others 0 → 17 words. Word 17 has idx 16, `out_data`=0xBEEF, `out_last`=1. `out_last`=0 on idx 15.
- Reset mid-dump at idx 7 in SEND → outputs 0 in the same cycle. New `start` → first word idx 0.
- Continuous mode: `cont`=1, pulse `start` again mid-dump → second `start` ignored. After idx 15, `done` pulses and idx 0 is selected next without IDLE; `busy` stays 1.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared types and constants for the register dump sequencer
package reg_dump_pkg;

    localparam int         NUM_REGS = 16;
    localparam int         REG_W    = 16;
    localparam logic [4:0] CSUM_IDX = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        SEND,
        CSUM
    } dump_state_t;

endpackage

// File: rtl/reg_dump_seq.sv
// rtl/reg_dump_seq.sv - walks the debug select 0..15 and streams each register out with its index
// Optional checksum trailer word: REG_DUMP_CSUM_EN
module reg_dump_seq
    import reg_dump_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        nClear,
    input  logic        start,
    input  logic        cont,
    output logic [3:0]  m_state,
    input  logic [31:0] m_data,
    output logic [15:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_IDX    = 4'(NUM_REGS - 1);

    dump_state_t state, state_nxt;
    logic [3:0]  idx;
    logic [3:0]  settle_cnt;
    logic        capture;
    logic        handshake;
    logic        final_hs;
    logic        last_reg;
    logic        unused_low;
`ifdef REG_DUMP_CSUM_EN
    logic [REG_W-1:0] acc;
`endif

    assign handshake  = out_valid & out_ready;
    assign last_reg   = (idx == LAST_IDX);
    assign m_state    = idx;
    assign busy       = (state != IDLE);
    assign unused_low = ^m_data[15:0];

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        final_hs  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SELECT;
                end
            end
            SELECT: begin
                if (settle_cnt == SETTLE_LAST) begin
                    capture   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (!last_reg) begin
                        state_nxt = SELECT;
                    end else begin
`ifdef REG_DUMP_CSUM_EN
                        state_nxt = CSUM;
`else
                        final_hs  = 1'b1;
                        state_nxt = cont ? SELECT : IDLE;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CSUM_EN
            CSUM: begin
                if (handshake) begin
                    final_hs  = 1'b1;
                    state_nxt = cont ? SELECT : IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
            out_data   <= '0;
            out_idx    <= 5'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
            acc        <= '0;
`endif
        end else begin
            done <= final_hs;

            if (state == IDLE && start) begin
                idx        <= 4'd0;
                settle_cnt <= 4'd0;
`ifdef REG_DUMP_CSUM_EN
                acc        <= '0;
`endif
            end

            if (state == SELECT) begin
                settle_cnt <= capture ? 4'd0 : settle_cnt + 4'd1;
            end

            if (capture) begin
                out_data  <= m_data[31:16];
                out_idx   <= {1'b0, idx};
                out_valid <= 1'b1;
`ifdef REG_DUMP_CSUM_EN
                out_last  <= 1'b0;
                acc       <= acc ^ m_data[31:16];
`else
                out_last  <= last_reg;
`endif
            end

            if (handshake) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if (state == SEND && !last_reg) begin
                    idx <= idx + 4'd1;
                end
            end

`ifdef REG_DUMP_CSUM_EN
            // Trailer goes out straight after the idx-15 handshake; acc already holds word 15.
            if (state == SEND && handshake && last_reg) begin
                out_data  <= acc;
                out_idx   <= CSUM_IDX;
                out_valid <= 1'b1;
                out_last  <= 1'b1;
            end
`endif

            if (final_hs) begin
                idx        <= 4'd0;
                settle_cnt <= 4'd0;
`ifdef REG_DUMP_CSUM_EN
                acc        <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_seq.sv
// tb/tb_reg_dump_seq.sv - self-checking bench for reg_dump_seq against a word-list reference model
module tb_reg_dump_seq;

    localparam int SETTLE = 1;
`ifdef REG_DUMP_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic [4:0]  idx;
        logic        is_last;
    } word_t;

    logic        clk;
    logic        nClear;
    logic        start;
    logic        cont;
    logic [3:0]  m_state;
    logic [31:0] m_data;
    logic [15:0] out_data;
    logic [4:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] regs [16];
    word_t       exp_q [$];
    int          errors = 0;
    int          checks = 0;

    assign m_data = {regs[m_state], regs[m_state + 4'd1]};

    reg_dump_seq #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .nClear    (nClear),
        .start     (start),
        .cont      (cont),
        .m_state   (m_state),
        .m_data    (m_data),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build_expected();
        logic [15:0] x;
        x = 16'h0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back('{data: regs[i], idx: 5'(i), is_last: (!CSUM_ON && i == 15)});
            x ^= regs[i];
        end
        if (CSUM_ON) exp_q.push_back('{data: x, idx: 5'd16, is_last: 1'b1});
    endtask

    // Runs one dump pass, checking every accepted word against exp_q and the done/busy tail.
    task automatic collect(input int ready_pct, input bit check_gap, input int pulse_cyc,
                           output int first_valid);
        int    cyc;
        int    last_hs;
        int    gap;
        bit    final_seen;
        bit    finished;
        bit    exp_cont;
        word_t e;
        cyc = 0; last_hs = -1; final_seen = 0; finished = 0; exp_cont = 0; first_valid = -1;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            start     = (cyc == pulse_cyc);
            out_ready = ($urandom_range(99) < ready_pct);
            if (final_seen) begin
                check("done_pulse", done, 1);
                check("busy_after_final", busy, exp_cont);
                if (exp_cont) check("restart_idx0", m_state, 0);
                finished = 1;
            end else begin
                check("busy_mid", busy, 1);
                check("done_quiet", done, 0);
                if (out_valid && first_valid < 0) first_valid = cyc;
                if (out_valid && out_ready) begin
                    check("words_left", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("word_data", out_data, e.data);
                        check("word_idx", out_idx, e.idx);
                        check("word_last", out_last, e.is_last);
                        if (check_gap && last_hs >= 0) begin
                            gap = (e.idx == 5'd16) ? 1 : SETTLE + 1;
                            check("word_gap", cyc - last_hs, gap);
                        end
                        last_hs = cyc;
                        if (exp_q.size() == 0) begin
                            final_seen = 1;
                            exp_cont   = cont;
                        end
                    end
                end
            end
            cyc++;
        end
        start = 1'b0;
        check("collect_finished", finished, 1);
    endtask

    initial begin
        int  fv;
        int  n;
        bit  seen;

        nClear = 1'b0; start = 1'b1; cont = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);

        // reset with start held high
        #22;
        check("rst_m_state", m_state, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        start = 1'b0; nClear = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_release", busy, 0);
        check("idle_no_valid", out_valid, 0);

        // basic dump, ready tied high
        build_expected();
        start = 1'b1;
        collect(100, 1, -1, fv);
        check("first_valid_latency", fv, SETTLE);
        @(negedge clk);
        check("idle_after_basic", busy, 0);

        // backpressure on idx 3
        build_expected();
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_idx == 5'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_idx3", out_idx, 3);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_data", out_data, 16'h1003);
            check("bp_hold_state", m_state, 3);
            check("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", out_valid, 0);
        repeat (SETTLE) @(negedge clk);
        check("bp_next_valid", out_valid, 1);
        check("bp_next_idx", out_idx, 4);
        check("bp_next_data", out_data, 16'h1004);
        seen = 0; n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            seen = done;
            n++;
        end
        check("bp_done_seen", seen, 1);

        // single non-zero register exercises the checksum path
        for (int i = 0; i < 16; i++) regs[i] = 16'h0;
        regs[5] = 16'hBEEF;
        build_expected();
        @(negedge clk);
        start = 1'b1;
        collect(100, 1, -1, fv);

        // random contents with random backpressure
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
            build_expected();
            @(negedge clk);
            start = 1'b1;
            collect(55, 0, -1, fv);
        end

        // asynchronous reset while idx 7 sits in SEND
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_idx == 5'd7) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached_idx7", out_idx, 7);
        out_ready = 1'b0;
        #2 nClear = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_data", out_data, 0);
        check("rst_mid_idx", out_idx, 0);
        check("rst_mid_state", m_state, 0);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        nClear = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_stays_idle", busy, 0);
        build_expected();
        start = 1'b1;
        collect(70, 0, -1, fv);

        // continuous mode with an ignored second start
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        build_expected();
        @(negedge clk);
        cont = 1'b1; start = 1'b1;
        collect(100, 1, 6, fv);
        cont = 1'b0;
        build_expected();
        collect(100, 1, -1, fv);
        check("cont_second_pass_first", fv, 0);
        @(negedge clk);
        check("cont_end_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
